// File: rtl/fp_div_pkg.sv
// Shared types and constants for the sequential single-precision divider.
// The operand-class enum and field widths are also used by fp_unpack_classify,
// which the combinational multiplier can reuse.
package fp_div_pkg;
  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int DIV_ITER = 26;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, PACK} state_e;
  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} op_class_e;
endpackage

// File: rtl/fp_unpack_classify.sv
// Combinational IEEE-754 single field split and class decode.
// Ports:
//   f    in  32  operand
//   sign out 1   sign bit
//   exp  out 8   biased exponent
//   mant out 24  mantissa with hidden 1 (0 for zero/subnormal)
//   cls  out     ZERO / NORMAL / INF / NAN
// With FTZ=1 any exp==0 operand is treated as signed zero. FTZ=0 is not
// supported: subnormals would then be misread as normals.
module fp_unpack_classify
  import fp_div_pkg::*;
#(
  parameter int FTZ = 1
) (
  input  logic [31:0]       f,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [MANT_W:0]   mant,
  output op_class_e         cls
);
  logic [MANT_W-1:0] frac;

  assign sign = f[31];
  assign exp  = f[30:MANT_W];
  assign frac = f[MANT_W-1:0];

  always_comb begin
    mant = {1'b1, frac};
    cls  = NORMAL;
    if (exp == '0 && (FTZ != 0 || frac == '0)) begin
      mant = '0;
      cls  = ZERO;
    end else if (exp == '1) begin
      cls = (frac == '0) ? INF : NAN;
    end
  end
endmodule

// File: rtl/fp_division_seq.sv
// Iterative IEEE-754 single-precision divider q = f_1 / f_2.
// Restoring radix-2 mantissa division, 26 iterations, FSM
// IDLE -> UNPACK -> DIVIDE -> NORM -> PACK -> IDLE (specials skip to PACK).
// Ports:
//   clk, rst_n  clock, async active-low reset
//   start       request, sampled only in IDLE (f_1/f_2 latched with it)
//   busy        high while an operation is in flight
//   done        one-cycle pulse; q/f_nan/f_inf valid from this cycle and held
//   f_nan/f_inf result class flags, shared convention with the multiplier
//   q           quotient
// Build option: FP_DIV_RNE_EN selects round-to-nearest-even, otherwise the
// mantissa is truncated.
module fp_division_seq
  import fp_div_pkg::*;
#(
  parameter logic [31:0] NAN_PATTERN = QNAN,
  parameter int          FTZ         = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] f_1,
  input  logic [31:0] f_2,
  output logic        busy,
  output logic        done,
  output logic        f_nan,
  output logic        f_inf,
  output logic [31:0] q
);
  state_e state, state_nxt;

  logic [31:0] a, b;
  logic        s1, s2;
  logic [7:0]  e1, e2;
  logic [23:0] m1, m2;
  op_class_e   c1, c2;

  fp_unpack_classify #(.FTZ(FTZ)) u_unp_a (.f(a), .sign(s1), .exp(e1), .mant(m1), .cls(c1));
  fp_unpack_classify #(.FTZ(FTZ)) u_unp_b (.f(b), .sign(s2), .exp(e2), .mant(m2), .cls(c2));

  logic              sign;
  logic signed [9:0] exp_r;
  logic [23:0]       mb;
  logic [25:0]       rem, quo;
  logic [4:0]        cnt;
  logic [22:0]       mant;
  logic              special, spec_nan, spec_inf;
  logic [31:0]       spec_q;
`ifdef FP_DIV_RNE_EN
  logic              guard, sticky;
`endif

  // ---- special-case decode (evaluated in UNPACK) ----
  logic        sp_hit, sp_nan, sp_inf;
  logic [31:0] sp_q;
  always_comb begin
    sp_hit = 1'b1;
    sp_nan = 1'b0;
    sp_inf = 1'b0;
    sp_q   = {s1 ^ s2, 31'h0};
    if (c1 == NAN || c2 == NAN || (c1 == ZERO && c2 == ZERO) || (c1 == INF && c2 == INF)) begin
      sp_q   = NAN_PATTERN;
      sp_nan = 1'b1;
    end else if (c2 == ZERO || c1 == INF) begin
      sp_q   = {s1 ^ s2, POS_INF[30:0]};
      sp_inf = 1'b1;
    end else if (!(c1 == ZERO || c2 == INF)) begin
      sp_hit = 1'b0;
    end
  end

  // ---- one restoring step ----
  logic        ge;
  logic [25:0] rem_sub, rem_nxt, quo_nxt;
  always_comb begin
    ge      = rem >= {2'b00, mb};
    rem_sub = ge ? rem - {2'b00, mb} : rem;
    // rem_sub < mb < 2^24, so dropping bit 25 on the shift loses nothing
    rem_nxt = {rem_sub[24:0], 1'b0};
    quo_nxt = {quo[24:0], ge};
  end

  // ---- rounding and final pack (evaluated in PACK) ----
  logic              rnd_inc, carry, pk_nan, pk_inf;
  logic [22:0]       mant_rnd;
  logic signed [9:0] exp_fin;
  logic [31:0]       pk_q;
  always_comb begin
`ifdef FP_DIV_RNE_EN
    rnd_inc = guard & (sticky | mant[0]);
`else
    rnd_inc = 1'b0;
`endif
    {carry, mant_rnd} = {1'b0, mant} + {23'h0, rnd_inc};
    // carry out of the mantissa means it wrapped to 0 and the exponent bumps
    exp_fin = exp_r + $signed({9'h0, carry});
    pk_nan  = 1'b0;
    pk_inf  = 1'b0;
    if (special) begin
      pk_q   = spec_q;
      pk_nan = spec_nan;
      pk_inf = spec_inf;
    end else if (exp_fin >= 10'sd255) begin
      pk_q   = {sign, POS_INF[30:0]};
      pk_inf = 1'b1;
    end else if (exp_fin <= 10'sd0) begin
      pk_q = {sign, 31'h0};
    end else begin
      pk_q = {sign, exp_fin[7:0], mant_rnd};
    end
  end

  // ---- FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = UNPACK;
      UNPACK:  state_nxt = sp_hit ? PACK : DIVIDE;
      DIVIDE:  if (cnt == 5'(DIV_ITER - 1)) state_nxt = NORM;
      NORM:    state_nxt = PACK;
      PACK:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // ---- datapath and result registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a        <= '0;
      b        <= '0;
      sign     <= 1'b0;
      exp_r    <= '0;
      mb       <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      mant     <= '0;
      special  <= 1'b0;
      spec_nan <= 1'b0;
      spec_inf <= 1'b0;
      spec_q   <= '0;
`ifdef FP_DIV_RNE_EN
      guard    <= 1'b0;
      sticky   <= 1'b0;
`endif
      done     <= 1'b0;
      f_nan    <= 1'b0;
      f_inf    <= 1'b0;
      q        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a     <= f_1;
          b     <= f_2;
          f_nan <= 1'b0;
          f_inf <= 1'b0;
        end
        UNPACK: begin
          sign     <= s1 ^ s2;
          exp_r    <= $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'(EXP_BIAS);
          rem      <= {2'b00, m1};
          mb       <= m2;
          quo      <= '0;
          cnt      <= '0;
          special  <= sp_hit;
          spec_q   <= sp_q;
          spec_nan <= sp_nan;
          spec_inf <= sp_inf;
        end
        DIVIDE: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 5'd1;
        end
        NORM: begin
          // quotient lies in (0.5, 2): Q[25] is the integer bit
          if (quo[25]) begin
            mant <= quo[24:2];
`ifdef FP_DIV_RNE_EN
            guard  <= quo[1];
            sticky <= quo[0] | (rem != '0);
`endif
          end else begin
            mant  <= quo[23:1];
            exp_r <= exp_r - 10'sd1;
`ifdef FP_DIV_RNE_EN
            guard  <= quo[0];
            sticky <= (rem != '0);
`endif
          end
        end
        PACK: begin
          q     <= pk_q;
          f_nan <= pk_nan;
          f_inf <= pk_inf;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_division_seq.sv
// Self-checking bench for fp_division_seq: expected results are queued when an
// operation is issued and compared when done pulses.
module tb_fp_division_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] f_1 = '0, f_2 = '0;
  logic        busy, done, f_nan, f_inf;
  logic [31:0] q;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] a, b, q;
    logic        nan, inf;
    int          lat;
  } exp_t;
  exp_t sb[$];

  fp_division_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f_1(f_1), .f_2(f_2),
    .busy(busy), .done(done), .f_nan(f_nan), .f_inf(f_inf), .q(q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one operation, wait for done (bounded), compare against the queue head.
  // With restart set, start is re-pulsed (with a different f_1) while busy;
  // it must be ignored and yield no extra done.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic en, input logic ei,
                       input int lat, input bit restart);
    exp_t e;
    int   edges;
    int   extra;
    bit   seen;
    e = '{a: a, b: b, q: eq, nan: en, inf: ei, lat: lat};
    sb.push_back(e);
    @(negedge clk);
    f_1 = a; f_2 = b; start = 1'b1;
    @(posedge clk);
    edges = 1;
    seen  = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        start = restart && edges >= 4 && edges <= 6;
        if (start) f_1 = 32'h3F800000;
        @(posedge clk);
        edges++;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout got=no_done exp=done", tag);
    end else begin
      chk({tag, "_q"},   q,     e.q);
      chk({tag, "_nan"}, f_nan, e.nan);
      chk({tag, "_inf"}, f_inf, e.inf);
      chk({tag, "_lat"}, edges, e.lat);
      chk({tag, "_busy"}, busy, 1'b0);
    end
    extra = 0;
    repeat (restart ? 40 : 2) begin
      @(negedge clk);
      if (done) extra++;
    end
    if (restart) chk({tag, "_single_done"}, extra, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    // reset state
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_nan",  f_nan, 1'b0);
    chk("rst_inf",  f_inf, 1'b0);
    chk("rst_q",    q, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 30, 0);
`ifdef FP_DIV_RNE_EN
    do_op("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 0, 0, 30, 0);
`else
    do_op("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0, 0, 30, 0);
`endif
    do_op("neg_div",   32'hBFC00000, 32'h3F000000, 32'hC0400000, 0, 0, 30, 1);
    do_op("ten_five",  32'h41200000, 32'h40A00000, 32'h40000000, 0, 0, 30, 0);
    do_op("x_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 0, 1, 3, 0);
    do_op("zero_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 1, 0, 3, 0);
    do_op("inf_inf",   32'h7F800000, 32'hFF800000, 32'h7FC00000, 1, 0, 3, 0);
    do_op("nan_op",    32'h7F800001, 32'h3F800000, 32'h7FC00000, 1, 0, 3, 0);
    do_op("inf_fin",   32'hFF800000, 32'h40000000, 32'hFF800000, 0, 1, 3, 0);
    do_op("nzero_fin", 32'h80000000, 32'h40000000, 32'h80000000, 0, 0, 3, 0);
    do_op("fin_inf",   32'h3F800000, 32'h7F800000, 32'h00000000, 0, 0, 3, 0);
    do_op("overflow",  32'h7F000000, 32'h3E800000, 32'h7F800000, 0, 1, 30, 0);
    chk("hold_q", q, 32'h7F800000);
    do_op("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 0, 0, 30, 0);
    do_op("ftz_in",    32'h00400000, 32'h3F800000, 32'h00000000, 0, 0, 3, 0);
    do_op("six_two_b", 32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 30, 0);

    // reset during DIVIDE (about iteration 10)
    @(negedge clk);
    f_1 = 32'h40C00000; f_2 = 32'h40000000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_q",    q, 32'h0);
    chk("midrst_nan",  f_nan, 1'b0);
    chk("midrst_inf",  f_inf, 1'b0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    do_op("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 30, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
